// File: rtl/rover_pkg.sv
// Shared types and constants for the rover sensor front-end.
package rover_pkg;
  localparam int INDUCT_W   = 3;
  localparam int INDUCT_MAX = 7;

  typedef enum logic {
    WARMUP  = 1'b0,
    MEASURE = 1'b1
  } gate_state_t;
endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser with an optional stable-count debouncer.
// With DEBOUNCE_EN=0 the output is the plain synchronised level.
module sync_debounce #(
  parameter bit DEBOUNCE_EN     = 1'b1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_out
);
  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

  generate
    if (DEBOUNCE_EN) begin : g_db
      localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
      logic [DB_W-1:0] r_db_cnt;
      logic            r_level;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_db_cnt <= '0;
          r_level  <= 1'b0;
        end else if (r_s2 == r_level) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_level  <= r_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end

      assign o_out = r_level;
    end else begin : g_nodb
      assign o_out = r_s2;
    end
  endgenerate
endmodule

// File: rtl/metal_sense_front.sv
// Gated oscillator counter -> baseline deficit -> 3-bit induct code, plus proximity debounce.
// Optional METAL_SENSE_HYST_EN: induct only moves after two matching consecutive window codes.
module metal_sense_front
  import rover_pkg::*;
#(
  parameter int GATE_CYCLES     = 100000,
  parameter int CNT_W           = 16,
  parameter int BASELINE        = 1000,
  parameter int SHIFT           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_osc_in,
  input  logic                i_prox_raw,
  output logic [INDUCT_W-1:0] o_induct,
  output logic                o_induct_valid,
  output logic                o_proxim
);
  localparam int WIN_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CNT_W:0] BASE_EXT = (CNT_W + 1)'(BASELINE);

  logic                w_osc_sync;
  logic                w_rise;
  logic                w_win_end;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [CNT_W:0]      w_deficit;
  logic [CNT_W:0]      w_shifted;
  logic [INDUCT_W-1:0] w_code;

  logic                r_osc_prev;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic [WIN_W-1:0]    r_win_cnt;
  gate_state_t         r_state;
`ifdef METAL_SENSE_HYST_EN
  logic [INDUCT_W-1:0] r_cand;
`endif

  sync_debounce #(.DEBOUNCE_EN(1'b0), .DEBOUNCE_CYCLES(2)) u_osc_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_osc_in), .o_out(w_osc_sync)
  );

  sync_debounce #(.DEBOUNCE_EN(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prox_db (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_prox_raw), .o_out(o_proxim)
  );

  assign w_rise    = w_osc_sync & ~r_osc_prev;
  assign w_win_end = (r_win_cnt == WIN_W'(GATE_CYCLES - 1));
  // Saturating count; also the final count when an edge lands in the terminal cycle.
  assign w_cnt_next = (w_rise && (r_edge_cnt != '1)) ? r_edge_cnt + 1'b1 : r_edge_cnt;

  always_comb begin
    w_deficit = '0;
    if ({1'b0, w_cnt_next} < BASE_EXT) w_deficit = BASE_EXT - {1'b0, w_cnt_next};
    w_shifted = w_deficit >> SHIFT;
    w_code    = (w_shifted > (CNT_W + 1)'(INDUCT_MAX)) ? INDUCT_W'(INDUCT_MAX)
                                                      : w_shifted[INDUCT_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_osc_prev     <= 1'b0;
      r_edge_cnt     <= '0;
      r_win_cnt      <= '0;
      r_state        <= WARMUP;
      o_induct       <= '0;
      o_induct_valid <= 1'b0;
`ifdef METAL_SENSE_HYST_EN
      r_cand         <= '0;
`endif
    end else begin
      r_osc_prev     <= w_osc_sync;
      o_induct_valid <= 1'b0;
      if (w_win_end) begin
        r_win_cnt  <= '0;
        r_edge_cnt <= '0;
        if (r_state == WARMUP) begin
          r_state <= MEASURE;
        end else begin
          o_induct_valid <= 1'b1;
`ifdef METAL_SENSE_HYST_EN
          if ((w_code == r_cand) && (w_code != o_induct)) o_induct <= w_code;
          r_cand <= w_code;
`else
          o_induct <= w_code;
`endif
        end
      end else begin
        r_win_cnt  <= r_win_cnt + 1'b1;
        r_edge_cnt <= w_cnt_next;
      end
    end
  end
endmodule

// File: doc/metal_sense_front.md
# metal_sense_front

Sensor front-end that sits directly upstream of the motor controller. It turns the raw inductive-coil oscillator into the 3-bit `induct` code the motor block consumes, and turns the raw IR proximity line into the debounced `proxim` flag. The block replaces the switch-driven test inputs on the rover top level. It is a gated frequency counter with baseline subtraction and quantisation, plus a synchroniser/debouncer.

## Interface
- `GATE_CYCLES`, 100000: measurement window length in `clk` cycles (1 ms at 100 MHz).
- `CNT_W`, 16: width of the oscillator edge counter; the counter saturates at all-ones.
- `BASELINE`, 1000: expected edge count per window with no metal present.
- `SHIFT`, 4: right-shift applied to the deficit before quantising.
- `DEBOUNCE_CYCLES`, 50000: number of stable cycles required before `proxim` changes.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `osc_in`  in  1: LC oscillator square wave, asynchronous to `clk`.
- `prox_raw`  in  1: IR proximity sensor output, asynchronous, may bounce.
- `induct`  out  3: quantised metal-strength code; 0 means no metal, 7 means strongest.
- `induct_valid`  out  1: one-cycle pulse each time a window result is produced.
- `proxim`  out  1: debounced proximity flag.

## Operation
- Synchronisation: `osc_in` and `prox_raw` each pass through a 2-FF synchroniser.
- Edge detection: a rising edge of synchronised `osc_in` increments `edge_cnt`. `edge_cnt` saturates at 2^CNT_W−1.
- Window timing: `win_cnt` counts 0..GATE_CYCLES−1 and then wraps.
- Gate FSM states:
  - WARMUP (entered on reset): runs one full window, then discards its result and moves to MEASURE. This suppresses synchroniser and oscillator start-up garbage.
  - MEASURE: at each window end, latches the final count (including an edge that arrives in the terminal cycle), computes the code, and clears `edge_cnt` for the next window. The FSM stays in MEASURE.
- Code arithmetic, using unsigned values:
  - deficit = BASELINE − count when count < BASELINE, otherwise 0.
  - code = min(deficit >> SHIFT, 7).
  - The deficit is computed at CNT_W+1 bits so that it cannot wrap.
- Proximity debounce: `db_cnt` resets whenever the synchronised `prox_raw` equals `proxim`. Otherwise `db_cnt` increments. When it reaches DEBOUNCE_CYCLES−1, `proxim` takes the new value and `db_cnt` clears.
- Reset values: `induct`=0, `induct_valid`=0, `proxim`=0, all counters 0, synchroniser flops 0, FSM=WARMUP. Reset asserted mid-window abandons that window and restarts in WARMUP.

## Timing
- Synchroniser latency: 2 cycles. The edge detector adds 1 more cycle.
- Results are produced on the clock after the terminal cycle (`win_cnt`=GATE_CYCLES−1). On that clock `induct` updates and `induct_valid` is high for exactly that one cycle.
- After `rst` deasserts, the first `induct_valid` occurs 2·GATE_CYCLES+1 cycles later.
- `proxim` changes DEBOUNCE_CYCLES+2 cycles after `prox_raw` becomes stable (2 of those cycles are synchroniser latency).
- `induct` holds its value between pulses. The motor block can sample it at any time.

## Configuration
- `METAL_SENSE_HYST_EN`
  - Defined: a newly computed code is held as a candidate. `induct` changes only when two consecutive windows produce the same code that differs from the current `induct`. `induct_valid` still pulses every window.
  - Undefined: `induct` takes the new code every window.

## Structure
- `rover_pkg` holds:
  - `INDUCT_W`=3
  - `INDUCT_MAX`=7
  - the gate FSM state typedef (WARMUP, MEASURE)
- The natural sub-module is `sync_debounce`, which combines the 2-FF synchroniser and the stable-count debouncer. It is instantiated for `prox_raw`. Its synchroniser alone (with debounce disabled) is reused for `osc_in`.

## Test plan
Bench parameters: GATE_CYCLES=1000, BASELINE=100, SHIFT=4, DEBOUNCE_CYCLES=10.
- Steady edge counts: 100 edges per window → `induct`=0; 84 edges → 1; 20 edges → 5; 150 edges → 0 (no underflow).
- Saturation and dead oscillator: with BASELINE=200 and 0 edges, `induct`=7.
- Reset and warmup: release `rst` → first `induct_valid` at cycle 2001 and never earlier. Assert `rst` at cycle 1500 → all outputs return to 0 immediately, and the next `induct_valid` comes 2001 cycles after release.
- Proximity debounce: pulses of 8 cycles on `prox_raw` → `proxim` stays 0. A level held high → `proxim` rises 12 cycles later. Release it → `proxim` falls 12 cycles after the release.
- Hysteresis (macro defined): window code sequence 0,3,0,3,3 → `induct` stays 0 through the fourth window and becomes 3 only after the fifth. With the macro undefined, `induct` follows every window's code.
